mac_operand_feeder: RTL and testbench

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

---
 rtl/mac_operand_feeder.sv | 154 +++++++++++++++
 tb/tb_mac_operand_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Buffers 8-bit operand pairs in a DEPTH-entry FIFO and feeds them, one pair
//   per cycle, to a downstream multiply-accumulate unit to form a VEC_LEN-term
//   dot product. A start request clears the accumulator (Clr), then streams
//   VEC_LEN pairs with En, stalling whenever the FIFO runs dry, and finally
//   pulses done.
//
//   Parameters
//     DEPTH    FIFO depth, power of two, 2..64
//     VEC_LEN  products per dot product, 1..255
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     wr_en        push one {a_in,b_in} pair (dropped while full)
//     a_in, b_in   operands to push
//     start        request one dot product (honoured only when idle)
//     full, empty  FIFO status
//     busy         a dot product is in progress
//     done         one-cycle pulse at the end of a dot product
//     Ain, Bin     registered operands to the MAC
//     En, Clr      registered accumulate-enable / accumulator-clear
//     drop_cnt     saturating count of dropped pushes
//                  (only when MAC_FEED_DROP_CNT_EN is defined)
module mac_operand_feeder #(
   parameter int DEPTH   = 8,
   parameter int VEC_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   input  logic       start,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       done,
   output logic [7:0] Ain,
   output logic [7:0] Bin,
   output logic       En,
   output logic       Clr
`ifdef MAC_FEED_DROP_CNT_EN
   ,
   output logic [7:0] drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [15:0]     mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      iss_q;
   logic [7:0]      ain_q, bin_q;
   logic            en_q, clr_q, done_q;
   logic            push, pop;
   logic            en_d, clr_d, done_d;

   // ---------------------------------------------------------------- FIFO
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   // Full blocks the push even when a pop frees a slot in the same cycle.
   assign push  = wr_en && !full;

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {a_in, b_in};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_RUN;
         // Leave RUN on the last pop so DONE coincides with the last En.
         S_RUN:   if (pop && iss_q == 8'(VEC_LEN - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop    = (state_q == S_RUN) && !empty && (iss_q < 8'(VEC_LEN));
      en_d   = pop;
      clr_d  = (state_d == S_CLEAR);
      done_d = (state_d == S_DONE);
   end

   // ------------------------------------------------- registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_q  <= '0;
         ain_q  <= '0;
         bin_q  <= '0;
         en_q   <= 1'b0;
         clr_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (state_q == S_CLEAR) iss_q <= '0;
         else if (pop)           iss_q <= iss_q + 1'b1;
         // Operands hold their last value through stalls.
         if (pop) {ain_q, bin_q} <= mem_q[rptr_q];
         en_q   <= en_d;
         clr_q  <= clr_d;
         done_q <= done_d;
      end
   end

   assign Ain  = ain_q;
   assign Bin  = bin_q;
   assign En   = en_q;
   assign Clr  = clr_q;
   assign done = done_q;
   assign busy = (state_q != S_IDLE);

`ifdef MAC_FEED_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   drop_cnt_q <= '0;
      else if (wr_en && full && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;

   localparam int DEPTH   = 8;
   localparam int VEC_LEN = 4;

   logic       clk, rst, wr_en, start;
   logic [7:0] a_in, b_in;
   logic       full, empty, busy, done, En, Clr;
   logic [7:0] Ain, Bin;
`ifdef MAC_FEED_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   mac_operand_feeder #(.DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .a_in(a_in), .b_in(b_in),
      .start(start), .full(full), .empty(empty), .busy(busy), .done(done),
      .Ain(Ain), .Bin(Bin), .En(En), .Clr(Clr)
`ifdef MAC_FEED_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO contents, every accepted pair in order, and a
   // downstream accumulator driven from the observed Clr/En/Ain/Bin.
   logic [15:0] fq[$];
   logic [15:0] all_pairs[$];
   int          dot_idx   = 0;
   int          done_cnt  = 0;
   int          en_total  = 0;
   int          drops     = 0;
   int          cyc       = 0;
   int          done_cyc  = 0;
   logic [31:0] acc       = 0;
   logic [31:0] last_sum  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dot_expect(input int base);
      logic [31:0] s = 0;
      for (int k = 0; k < VEC_LEN; k++)
         s += 32'(all_pairs[base + k][15:8]) * 32'(all_pairs[base + k][7:0]);
      return s;
   endfunction

   task automatic model_reset();
      fq.delete();
      all_pairs.delete();
      dot_idx = 0;
      acc     = 0;
   endtask

   // One clock: apply the previous cycle's MAC controls, take the edge,
   // update the model, and check what the DUT now presents.
   task automatic tick();
      logic        push_req;
      logic [15:0] pair_in;
      int          pre_size;
      logic [15:0] p;
      logic [31:0] fin;
      if (Clr)     acc = 0;
      else if (En) acc = acc + 32'(Ain) * 32'(Bin);
      push_req = wr_en && !rst;
      pair_in  = {a_in, b_in};
      pre_size = fq.size();
      @(posedge clk); #1;
      cyc++;
      if (push_req) begin
         if (pre_size < DEPTH) begin
            fq.push_back(pair_in);
            all_pairs.push_back(pair_in);
         end else drops++;
      end
      if (En) begin
         en_total++;
         if (fq.size() == 0) chk("en_with_pair", 32'(fq.size()), 1);
         else begin
            p = fq.pop_front();
            chk("pair_order", {16'd0, Ain, Bin}, {16'd0, p});
         end
      end
      chk("full",  full,  fq.size() == DEPTH);
      chk("empty", empty, fq.size() == 0);
      chk("clr_en_excl", Clr && En, 0);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         fin = acc + (En ? 32'(Ain) * 32'(Bin) : 0);
         last_sum = fin;
         if (all_pairs.size() < (dot_idx + 1) * VEC_LEN)
            chk("dot_pairs_avail", 32'(all_pairs.size()), 32'((dot_idx + 1) * VEC_LEN));
         else
            chk("dot_sum", fin, dot_expect(dot_idx * VEC_LEN));
         dot_idx++;
      end
   endtask

   task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
      wr_en = 1'b1; a_in = a; b_in = b;
      tick();
      wr_en = 1'b0;
   endtask

   // Issue a start from idle and wait (bounded) for its done pulse.
   task automatic run_dot(input string tag, output int lat);
      int st_cyc, base;
      st_cyc = cyc; base = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 200 && done_cnt == base; i++) tick();
      chk({tag, "_done_seen"}, done_cnt - base, 1);
      lat = done_cyc - st_cyc;
   endtask

   initial begin
      int lat, base, en_at, pushed, started;
      rst = 1'b1; wr_en = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
      #12;
      // ---- reset state
      chk("rst_Ain", Ain, 0);   chk("rst_Bin", Bin, 0);
      chk("rst_En", En, 0);     chk("rst_Clr", Clr, 0);
      chk("rst_done", done, 0); chk("rst_busy", busy, 0);
      chk("rst_full", full, 0); chk("rst_empty", empty, 1);
`ifdef MAC_FEED_DROP_CNT_EN
      chk("rst_drop", drop_cnt, 0);
`endif
      @(negedge clk); rst = 1'b0;
      tick();

      // ---- basic dot product (1,2)(3,4)(5,6)(7,8)
      push_pair(1, 2); push_pair(3, 4); push_pair(5, 6); push_pair(7, 8);
      start = 1'b1;
      base = cyc;
      tick();
      start = 1'b0;
      chk("t1_clr", Clr, 1);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_clr_once", Clr, 0);
      chk("t1_no_en_yet", En, 0);
      en_at = en_total;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_en_consec", En, 1);
      end
      chk("t1_en_count", en_total - en_at, 4);
      chk("t1_latency", done_cyc - base, VEC_LEN + 2);
      chk("t1_sum", last_sum, 100);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_en_off", En, 0);
      tick();
      chk("t1_idle", busy, 0);

      // ---- overfill: 9 pushes, no start
      for (int i = 0; i < 9; i++) begin
         push_pair(8'(10 + i), 8'(20 + i));
         if (i == 7) chk("t2_full_after_8", full, 1);
      end
      chk("t2_drops", drops, 1);
      chk("t2_still_full", full, 1);
`ifdef MAC_FEED_DROP_CNT_EN
      chk("t2_drop_cnt", drop_cnt, 1);
`endif
      run_dot("t2a", lat);
      chk("t2a_latency", lat, VEC_LEN + 2);
      tick();
      run_dot("t2b", lat);
      tick(); tick();
      chk("t2_drained", empty, 1);

      // ---- start on empty FIFO, trickle (2,3) every third cycle
      start = 1'b1; tick(); start = 1'b0;
      base = done_cnt;
      for (int i = 0; i < 4; i++) begin
         push_pair(2, 3);
         chk("t3_no_bypass", En, 0);
         tick();
         chk("t3_en_after_push", En, 1);
         if (i < 3) chk("t3_no_early_done", done_cnt - base, 0);
         if (i < 3) tick();
      end
      chk("t3_done", done_cnt - base, 1);
      chk("t3_sum", last_sum, 24);
      tick(); tick();

      // ---- start held while busy
      push_pair(9, 9); push_pair(1, 1); push_pair(4, 5); push_pair(6, 7);
      base = done_cnt;
      start = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("t4_one_done", done_cnt - base, 1);
      chk("t4_idle", busy, 0);

      // ---- reset after second En
      push_pair(5, 5); push_pair(6, 6); push_pair(7, 7); push_pair(8, 8);
      base = done_cnt;
      en_at = en_total;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 20 && en_total - en_at < 2; i++) tick();
      chk("t5_two_en", en_total - en_at, 2);
      #2 rst = 1'b1;
      #1;
      chk("t5_en", En, 0);
      chk("t5_busy", busy, 0);
      chk("t5_empty", empty, 1);
      chk("t5_done", done, 0);
      model_reset();
      tick();
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("t5_no_done", done_cnt - base, 0);

      // ---- 20 random pairs across 5 starts (pointer wrap)
      base = done_cnt; pushed = 0; started = 0;
      for (int i = 0; i < 3000 && done_cnt - base < 5; i++) begin
         wr_en = (pushed < 20) && (fq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         a_in  = 8'($urandom);
         b_in  = 8'($urandom);
         if (wr_en) pushed++;
         start = !busy && (started < 5) && ($urandom_range(0, 3) == 0);
         if (start) started++;
         tick();
      end
      wr_en = 1'b0; start = 1'b0;
      chk("t6_dots", done_cnt - base, 5);
      chk("t6_pushed", pushed, 20);
      tick(); tick();
      chk("t6_empty", empty, 1);
      chk("t6_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
